btn_debounce: RTL and testbench
===============================

Name: btn_debounce

Overview:
- Receiving end of the push-button interface on ui_in[3:0]: turns raw, bouncing, asynchronous button levels into clean debounced levels and single-cycle press/release events.
- Sits between the top-level ui_in pins and the seven-segment "fun" logic, which consumes only the btn_press and btn_release events.
- One independent channel per button.

Parameters:
- NUM_BTN, 4, number of button channels.
- CNT_W, 16, width of each per-channel stability counter.
- DEBOUNCE_CYCLES, 10000, consecutive stable cycles required to accept a new level. Legal range is 1 to 2^CNT_W-1; 10000 gives 1 ms at 10 MHz.
- REPEAT_DELAY, 5000000, cycles of hold before the first auto-repeat. Used only with the optional feature.
- REPEAT_PERIOD, 1000000, cycles between subsequent auto-repeats. Used only with the optional feature.

Ports:
- clk  in  1  system clock, 10 MHz nominal.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  design enable; low freezes counters and suppresses events.
- btn_raw  in  NUM_BTN  raw button levels, asynchronous, 1 = pressed.
- btn_state  out  NUM_BTN  debounced level.
- btn_press  out  NUM_BTN  one-cycle pulse on an accepted 0->1 transition.
- btn_release  out  NUM_BTN  one-cycle pulse on an accepted 1->0 transition.

Behaviour:
- Reset: one clock; rst is asynchronous and active-high. While rst=1, all sync flops, counters, btn_state, btn_press and btn_release are 0 immediately, without waiting for a clock edge.
- Synchroniser: each btn_raw bit passes through a 2-flop synchroniser, giving btn_s.
- Per-channel counter cnt (CNT_W bits):
  - btn_s == btn_state: cnt <= 0.
  - btn_s != btn_state and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - btn_s != btn_state and cnt == DEBOUNCE_CYCLES-1: btn_state toggles, cnt <= 0, and btn_press (new level 1) or btn_release (new level 0) is high for exactly that one cycle.
- Latency: let k be the first edge at which the first sync flop samples the new level. If the level stays unbroken, btn_state changes at edge k+1+DEBOUNCE_CYCLES.
- Bounce: any return of btn_s to the current btn_state before acceptance clears cnt. No event is produced.
- ena=0: sync flops keep running; cnt and btn_state hold; btn_press and btn_release are forced to 0. Counting resumes from the held cnt when ena returns to 1.
- Channels are fully independent. Simultaneous acceptances on several channels produce pulses in the same cycle.
- btn_press and btn_release are never both high on the same channel in the same cycle.
- Reset mid-count discards progress. After reset a full DEBOUNCE_CYCLES window is needed; a button held through reset yields one btn_press after the window.
- cnt never wraps; its maximum value is DEBOUNCE_CYCLES-1.

Optional Feature:
- Macro: BTN_DEBOUNCE_AUTOREPEAT_EN.
- Defined: each channel gets a repeat counter rcnt (32 bits), cleared whenever btn_state=0 or on an accepted press.
  - While btn_state=1 and ena=1, rcnt increments every cycle.
  - Extra one-cycle btn_press pulses occur REPEAT_DELAY cycles after the accepted press, then every REPEAT_PERIOD cycles while the button stays held.
  - Release clears rcnt and stops repeats.
- Undefined: no rcnt logic is built, the REPEAT_* parameters are ignored, and there is exactly one btn_press per accepted press.

Decomposition:
- Shared package btn_pkg holds:
  - NUM_BTN_DEFAULT = 4.
  - The 10 MHz clock constant CLK_HZ.
  - Function ms_to_cycles() for deriving DEBOUNCE_CYCLES.
  - Edge-type enum (EV_NONE, EV_PRESS, EV_RELEASE) for the bench scoreboard.
- One sub-module, btn_debounce_ch: synchroniser, counter, state and repeat logic for a single channel. The top generates it NUM_BTN times.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3, 100 ns clock):
- Reset: assert rst for 20 ns between edges -> all outputs read 0 before the next edge; hold btn_raw=4'hF through reset -> after release, btn_state=4'hF, with btn_press=4'hF for exactly one cycle.
- Bounce: toggle btn_raw[0] every 100 ns for 8 cycles, then hold it at 0 -> btn_press[0] never high, btn_state[0] stays 0.
- Clean press: hold btn_raw[1]=1 for 10 cycles -> btn_press[1] is a single one-cycle pulse at edge k+5, and btn_state[1]=1 from then on.
- Release with glitch: while btn[1] is held, drop it for 2 cycles -> no btn_release; then drop it for 6 cycles -> exactly one btn_release[1] pulse, and btn_state[1]=0.
- Simultaneous/ena: press btn2 and btn3 on the same edge -> both btn_press pulses appear in the same cycle; repeat with ena=0 for 3 cycles mid-count -> acceptance is delayed by exactly 3 cycles.
- Autorepeat (macro defined): hold btn_raw[0] for 20 cycles after acceptance -> btn_press[0] pulses at acceptance, +8, +11, +14, +17. With the macro undefined -> only the acceptance pulse.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared constants, helper function and event type for the button debouncer.
// Holds the default channel count, the 10 MHz clock constant and ms_to_cycles().
package btn_pkg;

  localparam int NUM_BTN_DEFAULT = 4;
  localparam int CLK_HZ = 10_000_000;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_PRESS,
    EV_RELEASE
  } btn_ev_e;

  function automatic int ms_to_cycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounce channel: 2-flop synchroniser, stability counter, debounced
// level and registered press/release pulses.
// Ports: clk_i, rst_i (async, active-high), ena_i, raw_i -> state_o,
// press_o, release_o.
// Optional macro BTN_DEBOUNCE_AUTOREPEAT_EN adds hold-to-repeat press pulses.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int          CNT_W           = 16,
  parameter int          DEBOUNCE_CYCLES = 10000,
  parameter int unsigned REPEAT_DELAY    = 5000000,
  parameter int unsigned REPEAT_PERIOD   = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ena_i,
  input  logic raw_i,
  output logic state_o,
  output logic press_o,
  output logic release_o
);

  if (DEBOUNCE_CYCLES < 1 ||
      64'(DEBOUNCE_CYCLES) > ((64'd1 << CNT_W) - 64'd1) ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("btn_debounce_ch: illegal timing parameters");
  end

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             state_q, state_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             rep_d;
  btn_ev_e          ev_d;

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    ev_d    = EV_NONE;
    if (ena_i) begin
      if (s2_q == state_q) begin
        cnt_d = '0;
      end else if (cnt_q == CntMax) begin
        cnt_d   = '0;
        state_d = s2_q;
        ev_d    = s2_q ? EV_PRESS : EV_RELEASE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  logic [31:0] rcnt_q, rcnt_d, rnext;

  // rcnt counts held cycles since acceptance; after the first repeat it
  // cycles through REPEAT_DELAY..REPEAT_DELAY+REPEAT_PERIOD-1.
  always_comb begin
    rcnt_d = rcnt_q;
    rep_d  = 1'b0;
    rnext  = rcnt_q + 32'd1;
    if (!state_q || !state_d) begin
      rcnt_d = '0;
    end else if (ena_i) begin
      rcnt_d = rnext;
      if (rnext == REPEAT_DELAY) begin
        rep_d = 1'b1;
      end else if (rnext == REPEAT_DELAY + REPEAT_PERIOD) begin
        rep_d  = 1'b1;
        rcnt_d = REPEAT_DELAY;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rcnt_q <= '0;
    else       rcnt_q <= rcnt_d;
  end
`else
  assign rep_d = 1'b0;
`endif

  assign press_d = (ev_d == EV_PRESS) | rep_d;
  assign rel_d   = (ev_d == EV_RELEASE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      state_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      s1_q    <= raw_i;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign state_o   = state_q;
  assign press_o   = press_q;
  assign release_o = rel_q;

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: NUM_BTN independent channels turning raw bouncing
// levels into debounced levels plus one-cycle press/release events.
// Ports: clk, rst (async, active-high), ena, btn_raw -> btn_state,
// btn_press, btn_release. Optional macro BTN_DEBOUNCE_AUTOREPEAT_EN.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int          NUM_BTN         = NUM_BTN_DEFAULT,
  parameter int          CNT_W           = 16,
  parameter int          DEBOUNCE_CYCLES = ms_to_cycles(1),
  parameter int unsigned REPEAT_DELAY    = 5000000,
  parameter int unsigned REPEAT_PERIOD   = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_state,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .CNT_W          (CNT_W),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk_i    (clk),
      .rst_i    (rst),
      .ena_i    (ena),
      .raw_i    (btn_raw[i]),
      .state_o  (btn_state[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce with a cycle-level reference model.
// Build with or without BTN_DEBOUNCE_AUTOREPEAT_EN.
module tb_btn_debounce;
  import btn_pkg::*;

  localparam int NB = 4;
  localparam int DC = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic          clk, rst, ena;
  logic [NB-1:0] btn_raw, btn_state, btn_press, btn_release;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [NB-1:0] m_st, m_pr, m_rl, m_p0, m_p1;
  int run  [NB];
  int hold [NB];

  btn_debounce #(
    .NUM_BTN        (NB),
    .CNT_W          (16),
    .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .btn_raw    (btn_raw),
    .btn_state  (btn_state),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  task automatic model_reset();
    m_st = '0; m_pr = '0; m_rl = '0; m_p0 = '0; m_p1 = '0;
    for (int c = 0; c < NB; c++) begin
      run[c]  = 0;
      hold[c] = 0;
    end
  endtask

  // Advance one clock: a channel accepts once its synchronised input has
  // differed from the accepted level for DC consecutive enabled cycles.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_pr = '0;
      m_rl = '0;
      if (ena) begin
        for (int c = 0; c < NB; c++) begin
          btn_ev_e ev;
          ev = EV_NONE;
          if (m_p0[c] != m_st[c]) begin
            run[c]++;
            if (run[c] == DC) begin
              run[c]  = 0;
              m_st[c] = m_p0[c];
              ev      = m_st[c] ? EV_PRESS : EV_RELEASE;
              hold[c] = 0;
            end
          end else begin
            run[c] = 0;
          end
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
          if (m_st[c] && ev == EV_NONE) begin
            hold[c]++;
            if (hold[c] >= RD && (hold[c] - RD) % RP == 0) ev = EV_PRESS;
          end
`endif
          m_pr[c] = (ev == EV_PRESS);
          m_rl[c] = (ev == EV_RELEASE);
        end
      end
      m_p0 = m_p1;
      m_p1 = btn_raw;
    end
    #1;
  endtask

  task automatic test_reset();
    int pc [NB];
    rst = 1'b1; ena = 1'b1; btn_raw = '0;
    #10;
    checks++;
    if ({btn_state, btn_press, btn_release} !== 12'h000) begin
      failures++;
      $display("FAIL reset_initial got=%h exp=000",
               {btn_state, btn_press, btn_release});
    end
    tick(); tick();
    rst = 1'b0;
    btn_raw = 4'hF;
    for (int t = 1; t <= 10; t++) begin
      tick();
      checks++;
      if ({btn_state, btn_press, btn_release} !== {m_st, m_pr, m_rl}) begin
        failures++;
        $display("FAIL reset_fill t=%0d got=%h exp=%h", t,
                 {btn_state, btn_press, btn_release}, {m_st, m_pr, m_rl});
      end
    end
    checks++;
    if (btn_state !== 4'hF) begin
      failures++;
      $display("FAIL reset_fill_state got=%h exp=f", btn_state);
    end
    #29 rst = 1'b1;
    #10;
    checks++;
    if ({btn_state, btn_press, btn_release} !== 12'h000) begin
      failures++;
      $display("FAIL reset_async got=%h exp=000",
               {btn_state, btn_press, btn_release});
    end
    #10 rst = 1'b0;
    model_reset();
    for (int c = 0; c < NB; c++) pc[c] = 0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      checks++;
      if ({btn_state, btn_press, btn_release} !== {m_st, m_pr, m_rl}) begin
        failures++;
        $display("FAIL reset_hold t=%0d got=%h exp=%h", t,
                 {btn_state, btn_press, btn_release}, {m_st, m_pr, m_rl});
      end
      for (int c = 0; c < NB; c++) pc[c] += int'(btn_press[c]);
      if (t == 6) begin
        checks++;
        if (btn_press !== 4'hF) begin
          failures++;
          $display("FAIL reset_press_edge got=%h exp=f", btn_press);
        end
      end
    end
    for (int c = 0; c < NB; c++) begin
      checks++;
      if (pc[c] != 1) begin
        failures++;
        $display("FAIL reset_press_count ch=%0d got=%0d exp=1", c, pc[c]);
      end
    end
    checks++;
    if (btn_state !== 4'hF) begin
      failures++;
      $display("FAIL reset_hold_state got=%h exp=f", btn_state);
    end
  endtask

  task automatic test_bounce();
    logic seen;
    btn_raw = '0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      checks++;
      if ({btn_state, btn_press, btn_release} !== {m_st, m_pr, m_rl}) begin
        failures++;
        $display("FAIL bounce_clear t=%0d got=%h exp=%h", t,
                 {btn_state, btn_press, btn_release}, {m_st, m_pr, m_rl});
      end
    end
    seen = 1'b0;
    btn_raw[0] = 1'b1;
    for (int t = 1; t <= 16; t++) begin
      tick();
      checks++;
      if ({btn_state, btn_press, btn_release} !== {m_st, m_pr, m_rl}) begin
        failures++;
        $display("FAIL bounce t=%0d got=%h exp=%h", t,
                 {btn_state, btn_press, btn_release}, {m_st, m_pr, m_rl});
      end
      seen |= btn_press[0];
      btn_raw[0] = (t < 8) ? ~btn_raw[0] : 1'b0;
    end
    checks++;
    if (seen !== 1'b0 || btn_state[0] !== 1'b0) begin
      failures++;
      $display("FAIL bounce_result press_seen=%b state=%b exp 0/0",
               seen, btn_state[0]);
    end
  endtask

  task automatic test_clean_press();
    int cnt, at;
    cnt = 0; at = -1;
    btn_raw[1] = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      checks++;
      if ({btn_state, btn_press, btn_release} !== {m_st, m_pr, m_rl}) begin
        failures++;
        $display("FAIL clean_press t=%0d got=%h exp=%h", t,
                 {btn_state, btn_press, btn_release}, {m_st, m_pr, m_rl});
      end
      if (btn_press[1]) begin
        cnt++;
        at = t;
      end
    end
    checks++;
    if (cnt != 1 || at != 6 || btn_state[1] !== 1'b1) begin
      failures++;
      $display("FAIL clean_press_pulse count=%0d at=%0d state=%b exp 1/6/1",
               cnt, at, btn_state[1]);
    end
  endtask

  task automatic test_release_glitch();
    int cnt, at;
    cnt = 0; at = -1;
    btn_raw[1] = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      checks++;
      if ({btn_state, btn_press, btn_release} !== {m_st, m_pr, m_rl}) begin
        failures++;
        $display("FAIL release_glitch t=%0d got=%h exp=%h", t,
                 {btn_state, btn_press, btn_release}, {m_st, m_pr, m_rl});
      end
      cnt += int'(btn_release[1]);
      if (t == 2) btn_raw[1] = 1'b1;
    end
    checks++;
    if (cnt != 0 || btn_state[1] !== 1'b1) begin
      failures++;
      $display("FAIL glitch_ignored releases=%0d state=%b exp 0/1",
               cnt, btn_state[1]);
    end
    cnt = 0;
    btn_raw[1] = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      checks++;
      if ({btn_state, btn_press, btn_release} !== {m_st, m_pr, m_rl}) begin
        failures++;
        $display("FAIL release t=%0d got=%h exp=%h", t,
                 {btn_state, btn_press, btn_release}, {m_st, m_pr, m_rl});
      end
      if (btn_release[1]) begin
        cnt++;
        at = t;
      end
    end
    checks++;
    if (cnt != 1 || at != 6 || btn_state[1] !== 1'b0) begin
      failures++;
      $display("FAIL release_pulse count=%0d at=%0d state=%b exp 1/6/0",
               cnt, at, btn_state[1]);
    end
  endtask

  task automatic test_simultaneous();
    int at2, at3;
    for (int pass = 0; pass < 2; pass++) begin
      at2 = -1; at3 = -1;
      btn_raw = 4'b1100;
      for (int t = 1; t <= 12; t++) begin
        tick();
        checks++;
        if ({btn_state, btn_press, btn_release} !== {m_st, m_pr, m_rl}) begin
          failures++;
          $display("FAIL simul p=%0d t=%0d got=%h exp=%h", pass, t,
                   {btn_state, btn_press, btn_release}, {m_st, m_pr, m_rl});
        end
        if (btn_press[2] && at2 < 0) at2 = t;
        if (btn_press[3] && at3 < 0) at3 = t;
        if (pass == 1 && t == 3) ena = 1'b0;
        if (t == 6) ena = 1'b1;
      end
      checks++;
      if (at2 != 6 + 3 * pass || at3 != 6 + 3 * pass) begin
        failures++;
        $display("FAIL simul_edge p=%0d got=%0d/%0d exp=%0d", pass,
                 at2, at3, 6 + 3 * pass);
      end
      btn_raw = '0;
      for (int t = 1; t <= 10; t++) begin
        tick();
        checks++;
        if ({btn_state, btn_press, btn_release} !== {m_st, m_pr, m_rl}) begin
          failures++;
          $display("FAIL simul_rel p=%0d t=%0d got=%h exp=%h", pass, t,
                   {btn_state, btn_press, btn_release}, {m_st, m_pr, m_rl});
        end
      end
    end
  endtask

  task automatic test_autorepeat();
    int got [$];
    int exp [$];
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    exp = '{6, 14, 17, 20, 23};
`else
    exp = '{6};
`endif
    btn_raw[0] = 1'b1;
    for (int t = 1; t <= 24; t++) begin
      tick();
      checks++;
      if ({btn_state, btn_press, btn_release} !== {m_st, m_pr, m_rl}) begin
        failures++;
        $display("FAIL autorepeat t=%0d got=%h exp=%h", t,
                 {btn_state, btn_press, btn_release}, {m_st, m_pr, m_rl});
      end
      if (btn_press[0]) got.push_back(t);
    end
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL autorepeat_pulses got=%p exp=%p", got, exp);
    end
    btn_raw[0] = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      checks++;
      if ({btn_state, btn_press, btn_release} !== {m_st, m_pr, m_rl}) begin
        failures++;
        $display("FAIL autorepeat_rel t=%0d got=%h exp=%h", t,
                 {btn_state, btn_press, btn_release}, {m_st, m_pr, m_rl});
      end
    end
  endtask

  task automatic test_random();
    int lim;
    for (int t = 0; t < 800; t++) begin
      lim = ((t / 100) % 2 == 0) ? 5 : 30;
      for (int c = 0; c < NB; c++)
        if ($urandom_range(lim) == 0) btn_raw[c] = ~btn_raw[c];
      ena = ($urandom_range(9) != 0);
      tick();
      checks++;
      if ({btn_state, btn_press, btn_release} !== {m_st, m_pr, m_rl}) begin
        failures++;
        $display("FAIL random t=%0d got=%h exp=%h", t,
                 {btn_state, btn_press, btn_release}, {m_st, m_pr, m_rl});
      end
      checks++;
      if ((btn_press & btn_release) !== '0) begin
        failures++;
        $display("FAIL random_both t=%0d got=%h exp=0", t,
                 btn_press & btn_release);
      end
    end
    ena = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_bounce();
    test_clean_press();
    test_release_glitch();
    test_simultaneous();
    test_autorepeat();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
